// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : adder_pkg
// Brief    : Shared types and elaboration helpers for the carry-select adders.
// Revision : 1.0
// ============================================================================
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of carry-select stages; never fewer than one.
    function automatic int num_blk(input int width, input int block);
        int n;
        n = width / block;
        return (n < 1) ? 1 : n;
    endfunction

    function automatic bit blk_fits(input int width, input int block);
        return (block > 0) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csel_block.sv
`default_nettype none
// ============================================================================
// Module   : csel_block
// Brief    : One carry-select block: both carry-in sums, picked by sel_cin.
// Revision : 1.0
// ============================================================================
module csel_block
    import adder_pkg::*;
#(
    parameter int BLOCK = 16
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             sel_cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK:0] w_sum0;
    logic [BLOCK:0] w_sum1;

    // Both candidates settle in parallel; the late-arriving carry only drives the mux.
    assign w_sum0 = {1'b0, a} + {1'b0, b};
    assign w_sum1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

    assign {cout, sum} = sel_cin ? w_sum1 : w_sum0;

endmodule
`default_nettype wire

// File: rtl/csel_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : csel_pipe_adder
// Brief    : Pipelined carry-select adder/subtractor, one block per stage,
//            valid/ready handshake on both sides.
// Revision : 1.0
// ============================================================================
module csel_pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int BLOCK = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] birinci_i,
    input  logic [WIDTH-1:0] ikinci_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] toplam_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int c_num_blk = num_blk(WIDTH, BLOCK);
    localparam int c_last    = c_num_blk - 1;

    if (!blk_fits(WIDTH, BLOCK)) begin : g_geometry_check
        $error("csel_pipe_adder: WIDTH must be a positive multiple of BLOCK");
    end

    op_e              w_op;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic             w_en;

    assign w_op       = op_e'(sub_i);
    assign w_b_eff    = (w_op == OP_SUB) ? ~ikinci_i : ikinci_i;
    assign w_c0       = (w_op == OP_SUB) ? 1'b1 : cin_i;
    assign w_en       = !out_valid_o || out_ready_i;
    assign in_ready_o = w_en;

    // Operand skew registers are kept right-aligned: the block a stage
    // consumes is always at bit 0. Result blocks enter from the top and
    // shift down, so the last stage holds the sum in its natural position.
    logic [c_num_blk-1:0] r_valid;
    logic [c_num_blk-1:0] r_carry;
    logic [c_num_blk-1:0] r_a_msb;
    logic [c_num_blk-1:0] r_b_msb;
    logic [WIDTH-1:0]     r_sum [c_num_blk];
    logic [WIDTH-1:0]     r_a   [c_num_blk];
    logic [WIDTH-1:0]     r_b   [c_num_blk];

    logic [c_num_blk-1:0] w_v_in;
    logic [c_num_blk-1:0] w_c_in;
    logic [c_num_blk-1:0] w_am_in;
    logic [c_num_blk-1:0] w_bm_in;
    logic [c_num_blk-1:0] w_blk_cout;
    logic [WIDTH-1:0]     w_a_in    [c_num_blk];
    logic [WIDTH-1:0]     w_b_in    [c_num_blk];
    logic [WIDTH-1:0]     w_s_in    [c_num_blk];
    logic [WIDTH-1:0]     w_sum_nxt [c_num_blk];
    logic [BLOCK-1:0]     w_blk_sum [c_num_blk];

    for (genvar k = 0; k < c_num_blk; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_v_in[k]  = in_valid_i;
            assign w_c_in[k]  = w_c0;
            assign w_am_in[k] = birinci_i[WIDTH-1];
            assign w_bm_in[k] = w_b_eff[WIDTH-1];
            assign w_a_in[k]  = birinci_i;
            assign w_b_in[k]  = w_b_eff;
            assign w_s_in[k]  = '0;
        end else begin : g_body
            assign w_v_in[k]  = r_valid[k-1];
            assign w_c_in[k]  = r_carry[k-1];
            assign w_am_in[k] = r_a_msb[k-1];
            assign w_bm_in[k] = r_b_msb[k-1];
            assign w_a_in[k]  = r_a[k-1];
            assign w_b_in[k]  = r_b[k-1];
            assign w_s_in[k]  = r_sum[k-1];
        end

        csel_block #(
            .BLOCK   (BLOCK)
        ) u_blk (
            .a       (w_a_in[k][BLOCK-1:0]),
            .b       (w_b_in[k][BLOCK-1:0]),
            .sel_cin (w_c_in[k]),
            .sum     (w_blk_sum[k]),
            .cout    (w_blk_cout[k])
        );

        assign w_sum_nxt[k] = (w_s_in[k] >> BLOCK) | (WIDTH'(w_blk_sum[k]) << (WIDTH - BLOCK));
    end

    // Single global enable: the whole pipe advances or holds, bubbles included.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_carry <= '0;
            r_a_msb <= '0;
            r_b_msb <= '0;
            for (int k = 0; k < c_num_blk; k++) begin
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else if (w_en) begin
            r_valid <= w_v_in;
            r_carry <= w_blk_cout;
            r_a_msb <= w_am_in;
            r_b_msb <= w_bm_in;
            for (int k = 0; k < c_num_blk; k++) begin
                r_sum[k] <= w_sum_nxt[k];
                r_a[k]   <= w_a_in[k] >> BLOCK;
                r_b[k]   <= w_b_in[k] >> BLOCK;
            end
        end
    end

    assign out_valid_o = r_valid[c_last];
    assign toplam_o    = r_sum[c_last];
    assign cout_o      = r_carry[c_last];
    assign ovf_o       = (r_a_msb[c_last] == r_b_msb[c_last]) &&
                         (r_sum[c_last][WIDTH-1] != r_a_msb[c_last]);

endmodule
`default_nettype wire

// File: doc/csel_pipe_adder.md
# csel_pipe_adder

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on both sides. It is the successor to the fixed 64-bit combinational carry-select adder. Operand width, block size and add/sub mode are configurable, with one carry-select block resolved per pipeline stage. It sits between the UART receive/operand-assembly logic and the UART transmit formatter, accepting one operation per cycle under backpressure.

## Interface
- WIDTH, default 64: operand/result width; must be a multiple of BLOCK.
- BLOCK, default 16: bits per carry-select block. NUM_BLK = WIDTH/BLOCK stages, minimum 1.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- in_valid_i  in  1  an operation is offered.
- in_ready_o  out  1  the block accepts the offered operation this cycle.
- birinci_i  in  WIDTH  operand A.
- ikinci_i  in  WIDTH  operand B.
- cin_i  in  1  carry in; ignored when sub_i=1.
- sub_i  in  1  0 = A+B+cin, 1 = A−B (A+~B+1).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- toplam_o  out  WIDTH  result.
- cout_o  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf_o  out  1  two's-complement signed overflow.

## Operation
- Effective operands:
  - B' = sub_i ? ~B : B.
  - c0 = sub_i ? 1 : cin_i.
- Stage k (k = 0..NUM_BLK−1) handles block k (bits k*BLOCK .. k*BLOCK+BLOCK−1):
  - Computes both block sums, one for carry-in 0 and one for carry-in 1.
  - Selects between them with the carry registered from stage k−1. Stage 0 uses c0.
- Operands for the blocks not yet processed travel with the token in skew registers. Finished result blocks are carried forward to the final stage.
- Per-stage state: valid bit, carry, partial result, remaining operand bits, and the MSB inputs needed for ovf.
- ovf = (A'[MSB] == B'[MSB]) && (sum[MSB] != A'[MSB]), where A' = A.
- cout is the final block's selected carry.
- Handshake: global enable en = !out_valid_o || out_ready_i.
  - in_ready_o = en.
  - When en=1, every stage advances. Stage 0 loads in_valid_i and the operand data.
  - When en=0, all stages hold.
  - Bubbles are not collapsed.
- A transfer happens on a cycle with valid && ready on the respective side.
- Results leave in issue order. None are dropped or duplicated.
- While out_valid_o=1 and out_ready_i=0, toplam_o, cout_o and ovf_o stay stable.

## Timing
- Latency: NUM_BLK cycles from input acceptance to out_valid_o (4 with the defaults).
- Throughput: 1 operation per cycle when out_ready_i is held at 1.
- Reset values (all applied asynchronously): every valid bit 0, every data/carry register 0, so out_valid_o=0, toplam_o=0, cout_o=0, ovf_o=0.
- in_ready_o returns 1 once out_valid_o=0. Inputs are ignored while rst_ni=0.
- Reset mid-operation: all in-flight tokens are discarded. No result from before reset ever appears.
- Simultaneous output pop and input push when full: both complete in the same cycle.
- NUM_BLK=1: degenerates to a single registered carry-select stage with latency 1.
- Worst-case combinational path: one BLOCK-bit ripple plus one mux level. It is independent of WIDTH.

## Structure
- Shared package adder_pkg holds:
  - op_e enum {OP_ADD, OP_SUB}, mapped to sub_i.
  - The function num_blk(WIDTH, BLOCK).
  - An elaboration check that WIDTH % BLOCK == 0.
- Sub-module csel_block (parameter BLOCK): combinational.
  - Inputs: a, b, sel_cin.
  - Outputs: sum, cout (the selected pair).
  - Built from two ripple adders and a mux.
  - Instantiated NUM_BLK times with a generate loop.
- csel_pipe_adder itself owns only the pipeline registers and the handshake logic.

## Test plan
Defaults apply (WIDTH=64, BLOCK=16, latency 4) unless stated otherwise.
- All-ones plus 1: A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0, add -> toplam 0, cout 1, ovf 0, valid 4 cycles after accept.
- Cross-block carry: A=0x0000_0000_FFFF_FFFF, B=1 -> 0x0000_0001_0000_0000, cout 0. Then A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> 0x8000_0000_0000_0000, ovf 1, cout 0.
- Subtract: A=5, B=7, sub=1, cin=1 (ignored) -> 0xFFFF_FFFF_FFFF_FFFE, cout 0, ovf 0. A=7, B=5 -> 2, cout 1.
- Backpressure: 6 back-to-back ops (A=i, B=i, i=1..6), out_ready_i low for cycles 5–8 -> in_ready_o low while the output is held, outputs stable, results 2,4,…,12 in order, no loss or duplication.
- Reset mid-flight: 3 ops in flight, rst_ni pulsed low for 1 cycle -> out_valid_o=0 immediately, none of the 3 results ever appear, a new op A=1, B=2 after reset -> 3.
- Parametric: WIDTH=8, BLOCK=4, 0xF0+0x10 -> 0x00, cout 1, latency 2. WIDTH=8, BLOCK=8, 0x7F+0x01 -> 0x80, ovf 1, latency 1.
